// File: rtl/add_share_arbiter_pkg.sv
// Shared constants for the shared-adder arbiter: default sizes, the
// output-slot state encoding and the well-known requester indices.
package add_share_arbiter_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_REQ = 4;

  typedef logic [0:0] state_t;
  localparam state_t ST_EMPTY = 1'b0;
  localparam state_t ST_FULL  = 1'b1;

  localparam int REQ_PC4 = 0;
  localparam int REQ_BR  = 1;
  localparam int REQ_BTB = 2;
  localparam int REQ_JR  = 3;

endpackage

// File: rtl/add_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans Req upward from Ptr with wrap-around and
// returns the first set index as a one-hot Grant (gated by Enable).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] Req,
  input  logic [ID_W-1:0]    Ptr,
  input  logic               Enable,
  output logic [NUM_REQ-1:0] Grant,
  output logic [ID_W-1:0]    Win,
  output logic               Any
);

  int   idx;
  logic found;

  always_comb begin
    idx   = 0;
    found = 1'b0;
    Win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(Ptr) + k) % NUM_REQ;
      if (!found && Req[idx]) begin
        found = 1'b1;
        Win   = ID_W'(idx);
      end
    end
    Any   = found & Enable;
    Grant = '0;
    if (Any) Grant[Win] = 1'b1;
  end

endmodule

// File: rtl/add_share_arbiter.sv
// One registered adder shared by NUM_REQ requesters through a round-robin
// arbiter, returning sum/carry/id via a one-entry valid/ready register.
module add_share_arbiter
  import add_share_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_REQ-1:0]       Req,
  input  logic [NUM_REQ*WIDTH-1:0] A_in,
  input  logic [NUM_REQ*WIDTH-1:0] B_in,
  output logic [NUM_REQ-1:0]       Grant,
  output logic [WIDTH-1:0]         Result,
  output logic                     Carry_Out,
  output logic [ID_W-1:0]          Result_Id,
  output logic                     Result_Valid,
  input  logic                     Result_Ready
);

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = A_in[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = B_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  state_t           state_q, state_d;

  logic             slot_free;
  logic             arb_en;
  logic             any_grant;
  logic [ID_W-1:0]  win;
  logic [WIDTH:0]   sum;

  // Grant is suppressed while reset is held, even though the flops are already cleared.
  assign slot_free = (state_q == ST_EMPTY) | Result_Ready;
  assign arb_en    = slot_free & Rst;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .Req   (Req),
    .Ptr   (ptr_q),
    .Enable(arb_en),
    .Grant (Grant),
    .Win   (win),
    .Any   (any_grant)
  );

  assign sum = {1'b0, a_arr[win]} + {1'b0, b_arr[win]};

  always_comb begin
    result_d = result_q;
    carry_d  = carry_q;
    id_d     = id_q;
    ptr_d    = ptr_q;
    state_d  = state_q;
    if (any_grant) begin
      result_d = sum[WIDTH-1:0];
      carry_d  = sum[WIDTH];
      id_d     = win;
      ptr_d    = ID_W'((int'(win) + 1) % NUM_REQ);
      state_d  = ST_FULL;
    end else if (Result_Ready) begin
      state_d  = ST_EMPTY;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      id_q     <= '0;
      ptr_q    <= '0;
      state_q  <= ST_EMPTY;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      id_q     <= id_d;
      ptr_q    <= ptr_d;
      state_q  <= state_d;
    end
  end

  assign Result       = result_q;
  assign Carry_Out    = carry_q;
  assign Result_Id    = id_q;
  assign Result_Valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_add_share_arbiter.sv
// Scoreboard bench for add_share_arbiter: a behavioural model predicts grants
// and results; a negedge monitor checks each result as it is consumed.
module tb_add_share_arbiter;
  import add_share_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic           Clk = 1'b0;
  logic           Rst = 1'b0;
  logic [N-1:0]   Req = '0;
  logic [N*W-1:0] A_in = '0;
  logic [N*W-1:0] B_in = '0;
  logic [N-1:0]   Grant;
  logic [W-1:0]   Result;
  logic           Carry_Out;
  logic [1:0]     Result_Id;
  logic           Result_Valid;
  logic           Result_Ready = 1'b0;

  add_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(2)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .A_in(A_in), .B_in(B_in),
    .Grant(Grant), .Result(Result), .Carry_Out(Carry_Out),
    .Result_Id(Result_Id), .Result_Valid(Result_Valid),
    .Result_Ready(Result_Ready)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    int           id;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] a_v [N];
  logic [W-1:0] b_v [N];
  int           m_ptr = 0;
  logic         m_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requester at or after the pointer, wrapping; -1 when nobody asks.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One cycle: present inputs, check the combinational grant, advance the model at the edge.
  task automatic drive(input logic [N-1:0] r, input logic rdy);
    int           w;
    logic [N-1:0] exp_g;
    longint       s;
    exp_t         e;
    Req = r;
    Result_Ready = rdy;
    for (int i = 0; i < N; i++) begin
      A_in[i*W +: W] = a_v[i];
      B_in[i*W +: W] = b_v[i];
    end
    #1;
    w = (!m_valid || rdy) ? pick(r, m_ptr) : -1;
    exp_g = '0;
    if (w >= 0) exp_g[w] = 1'b1;
    check("grant", 64'(Grant), 64'(exp_g));
    check("valid", 64'(Result_Valid), 64'(m_valid));
    @(posedge Clk);
    if (w >= 0) begin
      s = longint'(a_v[w]) + longint'(b_v[w]);
      e.sum = s[W-1:0];
      e.carry = s[W];
      e.id = w;
      sb.push_back(e);
      m_ptr = (w + 1) % N;
      m_valid = 1'b1;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    #2;
  endtask

  task automatic apply_reset();
    Rst = 1'b0;
    Req = '1;
    #1;
    check("rst_result", 64'(Result), 64'd0);
    check("rst_carry", 64'(Carry_Out), 64'd0);
    check("rst_id", 64'(Result_Id), 64'd0);
    check("rst_valid", 64'(Result_Valid), 64'd0);
    check("rst_grant", 64'(Grant), 64'd0);
    sb.delete();
    m_ptr = 0;
    m_valid = 1'b0;
    @(posedge Clk);
    #2;
    Rst = 1'b1;
  endtask

  always @(negedge Clk) begin
    if (Rst && Result_Valid && Result_Ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got id=%0d sum=%h expected no result", Result_Id, Result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("[TB] result id=%0d sum=%h carry=%0d (expected id=%0d sum=%h carry=%0d)",
                 Result_Id, Result, Carry_Out, e.id, e.sum, e.carry);
        check("result_sum", 64'(Result), 64'(e.sum));
        check("result_carry", 64'(Carry_Out), 64'(e.carry));
        check("result_id", 64'(Result_Id), 64'(e.id));
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    @(posedge Clk);
    #2;
    apply_reset();

    // Single PC+4 style request
    a_v[REQ_PC4] = 32'h0000_0004;
    b_v[REQ_PC4] = 32'h0040_0000;
    drive(4'b0001, 1'b1);
    drive(4'b0000, 1'b1);

    // All requesting: strict rotation with fresh operands each cycle
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) begin
        a_v[i] = $urandom;
        b_v[i] = $urandom;
      end
      drive(4'b1111, 1'b1);
    end

    // Carry out of the top bit
    a_v[REQ_BR] = 32'hFFFF_FFFF;
    b_v[REQ_BR] = 32'h0000_0002;
    drive(4'b0010, 1'b1);

    // Backpressure holds the result and blocks grants
    a_v[REQ_BTB] = 32'h1234_5678;
    b_v[REQ_BTB] = 32'h1111_1111;
    for (int c = 0; c < 3; c++) drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b1);
    drive(4'b0000, 1'b1);

    // Reset mid-stream with a pending result and the pointer at 2
    drive(4'b0010, 1'b1);
    apply_reset();
    for (int c = 0; c < 4; c++) drive(4'b1111, 1'b1);

    // Requester 3 gives up while blocked; nothing of its own appears
    drive(4'b0001, 1'b1);
    drive(4'b1000, 1'b0);
    drive(4'b1000, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b1);

    // Random traffic with occasional wrap-around operands
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        a_v[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        b_v[i] = $urandom;
      end
      drive(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end

    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b1);
    check("drained_queue", 64'(sb.size()), 64'd0);
    check("drained_valid", 64'(Result_Valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
